// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: shadows FIFO occupancy from the write strobe and drains the FIFO
// into a 2-entry valid/ready output buffer, with level status and sticky error flags.
module fifo_drain_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LVL_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_wr_n,
  output logic                  fifo_rd_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_over_flow,
  input  logic                  fifo_under_flow,
  input  logic                  en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LVL_W-1:0]      level,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clr
);
  localparam logic [LVL_W-1:0] CNT_MAX = LVL_W'(FIFO_DEPTH - 1);
  logic [LVL_W-1:0] cnt;
  logic pend;
  logic [1:0] buf_cnt;
  logic [DATA_WIDTH-1:0] b0, b1;
  logic wr_acc, rd_acc, pop, push0, push1;
  logic [2:0] credit;
  logic [1:0] slot;
  // credit counts buffer entries still owed after this cycle's pop, including the in-flight read
  always_comb begin
    wr_acc = !fifo_wr_n && cnt != CNT_MAX;
    pop    = m_valid && m_ready;
    credit = {1'b0, buf_cnt} + {2'b0, pend} - {2'b0, pop};
    rd_acc = en && cnt != '0 && credit <= 3'd1;
    slot   = buf_cnt - {1'b0, pop};
    push0  = pend && slot == 2'd0;
    push1  = pend && slot == 2'd1;
  end
  assign fifo_rd_n  = !rd_acc;
  assign m_valid    = buf_cnt != 2'd0;
  assign m_data     = b0;
  assign level      = cnt;
  assign fifo_empty = cnt == '0;
  assign fifo_full  = cnt == CNT_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt           <= '0;
      pend          <= 1'b0;
      buf_cnt       <= 2'd0;
      b0            <= '0;
      b1            <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      cnt           <= cnt + LVL_W'(wr_acc) - LVL_W'(rd_acc);
      pend          <= rd_acc;
      buf_cnt       <= buf_cnt + {1'b0, pend} - {1'b0, pop};
      b0            <= push0 ? fifo_dout : pop ? b1 : b0;
      b1            <= push1 ? fifo_dout : b1;
      err_overflow  <= fifo_over_flow | (err_overflow & !err_clr);
      err_underflow <= fifo_under_flow | (err_underflow & !err_clr);
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed and randomized checks of fifo_drain_ctrl against a
// behavioural FIFO plus an in-order scoreboard of accepted writes.
module tb_fifo_drain_ctrl;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst_n, wr_n, rd_n, en, m_ready, err_clr;
  logic fovf, funf, m_valid, empty, full, eovf, eunf;
  logic [7:0] wdata, fdout, m_data;
  logic [3:0] level;
  int tests = 0, fails = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic exp_eovf, exp_eunf, stall;
  logic [7:0] last_data;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_wr_n(wr_n), .fifo_rd_n(rd_n), .fifo_dout(fdout),
    .fifo_over_flow(fovf), .fifo_under_flow(funf), .en(en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .level(level), .fifo_empty(empty),
    .fifo_full(full), .err_overflow(eovf), .err_underflow(eunf), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Attached FIFO (full check before the edge, registered dout/flags) and stream scoreboard
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete(); exp_q.delete();
      fdout <= '0; fovf <= 1'b0; funf <= 1'b0;
      exp_eovf = 1'b0; exp_eunf = 1'b0; stall = 1'b0; last_data = '0;
    end else begin
      automatic bit f_full = mq.size() == DEPTH - 1;
      automatic bit f_empty = mq.size() == 0;
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, last_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("stream_data", m_data, exp_q.pop_front());
      end
      stall = m_valid && !m_ready;
      last_data = m_data;
      exp_eovf = fovf | (exp_eovf & !err_clr);
      exp_eunf = funf | (exp_eunf & !err_clr);
      fovf <= !wr_n && f_full;
      funf <= !rd_n && f_empty;
      if (!rd_n && !f_empty) fdout <= mq.pop_front();
      if (!wr_n && !f_full) begin
        mq.push_back(wdata);
        exp_q.push_back(wdata);
      end
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_n"}, rd_n, 1);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_eovf"}, eovf, 0);
    chk({tag, "_eunf"}, eunf, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_n = 1'b1; wdata = '0; en = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    #1 chk_reset("por");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // basic drain
    en = 1'b1; m_ready = 1'b1;
    wr_n = 1'b0; wdata = 8'h11; #1 chk("drain_c0_rd", rd_n, 1); chk("drain_c0_lvl", level, 0);
    tick(); wdata = 8'h22; #1 chk("drain_c1_rd", rd_n, 0); chk("drain_c1_lvl", level, 1);
    tick(); wdata = 8'h33; #1 chk("drain_c2_valid", m_valid, 0);
    tick(); wr_n = 1'b1; #1 chk("drain_c3_valid", m_valid, 1); chk("drain_c3_data", m_data, 8'h11);
    tick(); #1 chk("drain_c4_valid", m_valid, 1); chk("drain_c4_data", m_data, 8'h22);
    tick(); #1 chk("drain_c5_valid", m_valid, 1); chk("drain_c5_data", m_data, 8'h33);
    tick(); #1 chk("drain_c6_valid", m_valid, 0); chk("drain_c6_lvl", level, 0); chk("drain_c6_empty", empty, 1);
    // enable gating
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); wr_n = 1'b0; wdata = 8'h50 + 8'(i); #1 chk("gate_rd", rd_n, 1);
    end
    tick(); wr_n = 1'b1; #1 chk("gate_lvl", level, 5); chk("gate_valid", m_valid, 0); chk("gate_rd_idle", rd_n, 1);
    tick(); en = 1'b1; #1 chk("gate_en_rd", rd_n, 0);
    tick(); #1 chk("gate_en_valid_early", m_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1 chk("gate_out_valid", m_valid, 1); chk("gate_out_data", m_data, 8'h50 + 8'(i));
    end
    tick(); #1 chk("gate_done_valid", m_valid, 0); chk("gate_done_lvl", level, 0);
    // backpressure, full, overflow, simultaneous at full, error clear
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick(); wr_n = 1'b0; wdata = 8'(i);
    end
    tick(); wr_n = 1'b1; #1
    chk("bp_lvl", level, 15); chk("bp_full", full, 1); chk("bp_valid", m_valid, 1); chk("bp_head", m_data, 0);
    tick(); wr_n = 1'b0; wdata = 8'h99; #1 chk("ovf_t0_err", eovf, 0);
    tick(); wr_n = 1'b1; #1 chk("ovf_t1_err", eovf, 0); chk("ovf_t1_lvl", level, 15);
    tick(); m_ready = 1'b1; wr_n = 1'b0; wdata = 8'hAA; #1
    chk("ovf_t2_err", eovf, 1); chk("sim_rd", rd_n, 0); chk("sim_data0", m_data, 0);
    tick(); wr_n = 1'b1; err_clr = 1'b1; #1 chk("sim_lvl", level, 14); chk("sim_data1", m_data, 1);
    tick(); err_clr = 1'b0; #1 chk("clr_vs_set", eovf, 1); chk("bp_data2", m_data, 2);
    tick(); err_clr = 1'b1; #1 chk("bp_data3", m_data, 3);
    tick(); err_clr = 1'b0; #1 chk("clr_done", eovf, 0); chk("bp_data4", m_data, 4);
    for (int i = 5; i < 17; i++) begin
      tick(); #1 chk("bp_burst_valid", m_valid, 1); chk("bp_burst_data", m_data, 8'(i));
    end
    tick(); #1 chk("bp_end_valid", m_valid, 0); chk("bp_end_lvl", level, 0);
    // reset mid-stream with the buffer full
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); wr_n = 1'b0; wdata = 8'hC0 + 8'(i);
    end
    tick(); wr_n = 1'b1;
    tick(); tick(); #1 chk("pre_rst_valid", m_valid, 1); chk("pre_rst_lvl", level, 2);
    #1 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1 chk("post_rst_valid", m_valid, 0); chk("post_rst_rd", rd_n, 1);
    end
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      wr_n = $urandom_range(0, 2) == 0;
      wdata = 8'($urandom);
      en = $urandom_range(0, 7) != 0;
      m_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      err_clr = $urandom_range(0, 15) == 0;
      #1;
      chk("rnd_lvl", level, mq.size());
      chk("rnd_empty", empty, mq.size() == 0);
      chk("rnd_full", full, mq.size() == DEPTH - 1);
      chk("rnd_eovf", eovf, exp_eovf);
      chk("rnd_eunf", eunf, exp_eunf);
    end
    tick(); wr_n = 1'b1; en = 1'b1; m_ready = 1'b1; err_clr = 1'b0;
    repeat (40) tick();
    #1 chk("final_pending", exp_q.size(), 0); chk("final_valid", m_valid, 0); chk("final_lvl", level, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the team's synchronous FIFO (`fifo_dut`, active-low `wr_n`/`rd_n`, registered `dout`, registered `over_flow`/`under_flow`). It shadows FIFO occupancy by monitoring the producer's write strobe, since the FIFO exports no empty/full flags. It issues read strobes and converts the FIFO's one-cycle read latency into a valid/ready stream with a 2-entry output buffer. It also returns level/full/empty status to the producer and latches sticky error flags.

## Interface
- `FIFO_DEPTH`, 16: depth of the attached FIFO; power of two, ≥4. Usable capacity is FIFO_DEPTH-1 entries.
- `DATA_WIDTH`, 8: data width.
- `LVL_W`, $clog2(FIFO_DEPTH): width of `level`.
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; shared with the FIFO.
- `fifo_wr_n`  in  1  producer's write strobe to the FIFO (monitored only).
- `fifo_rd_n`  out  1  read strobe to the FIFO, active low, combinational.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data.
- `fifo_over_flow`  in  1  FIFO overflow indication.
- `fifo_under_flow`  in  1  FIFO underflow indication.
- `en`  in  1  drain enable; when low, no new reads are issued.
- `m_valid`  out  1  output data valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_WIDTH  output data.
- `level`  out  LVL_W  shadow FIFO occupancy, 0..FIFO_DEPTH-1.
- `fifo_empty`  out  1  `level == 0`.
- `fifo_full`  out  1  `level == FIFO_DEPTH-1`.
- `err_overflow`  out  1  sticky; set when `fifo_over_flow` is sampled high.
- `err_underflow`  out  1  sticky; set when `fifo_under_flow` is sampled high.
- `err_clr`  in  1  synchronous clear of both sticky flags. A set event in the same cycle wins.

## Operation
- Shadow count `cnt` (registered, drives `level`):
  - wr_acc = !fifo_wr_n && cnt != FIFO_DEPTH-1
  - rd_acc = !fifo_rd_n (only issued when cnt != 0)
  - Next value: cnt + wr_acc − rd_acc.
- Simultaneous events:
  - Write and read both accepted: cnt unchanged.
  - Write when cnt==DEPTH-1 is rejected even if a read occurs in the same cycle, matching the FIFO's pre-edge full check.
  - Write when cnt==0 does not enable a read in the same cycle.
- `pend` flag: set at the edge where rd_acc is true. During the following cycle `fifo_dout` holds the read word, which is pushed into the output buffer at that cycle's closing edge.
- Output buffer: 2-entry in-order FIFO with count `buf_cnt` (0..2).
  - m_valid = buf_cnt != 0; m_data = head entry.
  - pop = m_valid && m_ready.
  - Push (pend) and pop in the same cycle are both honoured.
- Read issue: fifo_rd_n = !(en && cnt != 0 && (buf_cnt + pend − pop) ≤ 1). This credit check prevents buffer overflow and sustains one word per cycle under continuous m_ready.
- Stream rules: while m_valid && !m_ready, m_data and m_valid hold. Data order equals FIFO write order.
- `en` deassert: reads stop immediately. A pending read still lands in the buffer; buffered data still drains.
- Overflow errors: writes rejected by the shadow count rely on the FIFO's own rejection; `err_overflow` reports them.

## Timing
- Reset values: fifo_rd_n=1, m_valid=0, m_data=0, level=0, fifo_empty=1, fifo_full=0, err_overflow=0, err_underflow=0. cnt, pend, buf_cnt and buffer contents are cleared.
- Write-to-level: a write accepted at edge E0 appears in `level` after E0.
- Read latency: fifo_rd_n low in cycle t → pend high in t+1 → m_valid high in t+2.
- First-word latency: write accepted at end of cycle 0 → fifo_rd_n low in cycle 1 → m_valid in cycle 3.
- Error latency: a rejected write in cycle t → FIFO over_flow high in t+1 → err_overflow high from t+2.
- Reset mid-operation: all state drops immediately, in step with the FIFO. The pending read is discarded and the buffer is emptied. No spurious m_valid after release.

## Test plan
- Reset: assert rst_n=0 mid-stream with buffer full → all outputs at reset values within the same cycle; after release, with no writes, m_valid stays 0 and fifo_rd_n stays 1.
- Basic drain: en=1, m_ready=1; write 0x11, 0x22, 0x33 in cycles 0–2 → m_valid in cycles 3–5 with m_data 0x11, 0x22, 0x33; level returns to 0; fifo_empty=1.
- Backpressure/full: m_ready=0; write 0x00..0x10 (17 words) → buffer holds 0x00, 0x01; level=15; fifo_full=1. An 18th write → err_overflow=1 two cycles later. Raise m_ready → 0x00..0x10 emitted on 17 consecutive cycles.
- Simultaneous at full: level=15, write and read accepted in the same cycle → write rejected, level=14, next output word unaffected.
- Enable gating: en=0; write 5 words → fifo_rd_n stays 1, level=5, m_valid=0. Set en=1 → five words out in order, first m_valid two cycles after en rises.
- Error clear: pulse err_clr after overflow → err_overflow=0 next cycle. err_clr coinciding with fifo_over_flow=1 → flag stays 1.
